// File: rtl/icetap_pkg.sv
// Shared icetap definitions: capture state encodings, also used by the STATUS scan register formatting.
package icetap_pkg;

  localparam int ICETAP_STATE_W = 2;

  typedef enum logic [ICETAP_STATE_W-1:0] {
    ICETAP_ST_IDLE         = 2'd0,
    ICETAP_ST_PRE_TRIGGER  = 2'd1,
    ICETAP_ST_POST_TRIGGER = 2'd2,
    ICETAP_ST_DONE         = 2'd3
  } icetap_state_e;

endpackage

// File: rtl/icetap_capture_ctrl_if.sv
// Sample RAM write port driven by the icetap capture sequencer (master) into the sample RAM (slave).
interface icetap_capture_ctrl_if #(
  parameter int NR_SIGNALS = 1,
  parameter int ADDR_BITS  = 8
);
  logic                  ram_wr_ena;
  logic [ADDR_BITS-1:0]  ram_wr_addr;
  logic [NR_SIGNALS-1:0] ram_wr_data;

  modport master (output ram_wr_ena, output ram_wr_addr, output ram_wr_data);
  modport slave  (input  ram_wr_ena, input  ram_wr_addr, input  ram_wr_data);
endinterface

// File: rtl/icetap_trigger_match.sv
// Registers the probed signals once and evaluates the store and trigger conditions on that sample.
module icetap_trigger_match #(
  parameter int NR_SIGNALS = 1
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [NR_SIGNALS-1:0] signals,
  input  logic [NR_SIGNALS-1:0] store_mask,
  input  logic [NR_SIGNALS-1:0] trigger_mask,
  input  logic [NR_SIGNALS-1:0] trigger_value,
  output logic [NR_SIGNALS-1:0] sig_d,
  output logic                  store_cond,
  output logic                  trig_cond
);

  logic [NR_SIGNALS-1:0] sig_prev;

  // Input register stage: sig_prev trails sig_d by one sample for change detection
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sig_d    <= '0;
      sig_prev <= '0;
    end else begin
      sig_d    <= signals;
      sig_prev <= sig_d;
    end
  end

  // An all-zero store mask means every sample is stored
  assign store_cond = (store_mask == '0) || (((sig_d ^ sig_prev) & store_mask) != '0);
  assign trig_cond  = ((sig_d & trigger_mask) == (trigger_value & trigger_mask));

endmodule

// File: rtl/icetap_capture_ctrl.sv
// icetap capture sequencer: arms on cmd_start, stores samples, triggers, and fills the post-trigger window.
// Optional build macro ICETAP_PRETRIG_WRAP_EN enables circular pre-trigger storage.
module icetap_capture_ctrl
  import icetap_pkg::*;
#(
  parameter int NR_SIGNALS = 1,
  parameter int ADDR_BITS  = 8
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic [NR_SIGNALS-1:0]     signals,
  input  logic                      cmd_start,
  input  logic                      cmd_stop,
  input  logic [NR_SIGNALS-1:0]     store_mask,
  input  logic [NR_SIGNALS-1:0]     trigger_mask,
  input  logic [NR_SIGNALS-1:0]     trigger_value,
  input  logic [ADDR_BITS-1:0]      post_trig_len,
  icetap_capture_ctrl_if.master     ram,
  output logic [ICETAP_STATE_W-1:0] state,
  output logic [ADDR_BITS-1:0]      trigger_addr,
  output logic [ADDR_BITS-1:0]      last_addr,
  output logic                      wrapped
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);

  logic [NR_SIGNALS-1:0] sig_d;
  logic                  store_cond;
  logic                  trig_cond;

  icetap_state_e        state_q, state_nxt;
  logic [ADDR_BITS-1:0] ptr_q, ptr_nxt, ptr_inc;
  logic [ADDR_BITS-1:0] cnt_q, cnt_nxt;
  logic [ADDR_BITS:0]   cnt_inc;
  logic [ADDR_BITS-1:0] trig_addr_q, trig_addr_nxt;
  logic                 wrapped_q, wrapped_nxt;
  logic                 wr_nxt;
  logic                 wr_ena_q;
  logic [ADDR_BITS-1:0] wr_addr_q;
  logic [NR_SIGNALS-1:0] wr_data_q;

  icetap_trigger_match #(.NR_SIGNALS(NR_SIGNALS)) u_match (
    .clk           (clk),
    .reset_        (reset_),
    .signals       (signals),
    .store_mask    (store_mask),
    .trigger_mask  (trigger_mask),
    .trigger_value (trigger_value),
    .sig_d         (sig_d),
    .store_cond    (store_cond),
    .trig_cond     (trig_cond)
  );

  assign ptr_inc = ptr_q + ADDR_ONE;
  assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state_q <= ICETAP_ST_IDLE;
    else         state_q <= state_nxt;
  end

  // Decision stage: start beats stop, stop beats any write in the same cycle
  always_comb begin
    state_nxt     = state_q;
    ptr_nxt       = ptr_q;
    cnt_nxt       = cnt_q;
    trig_addr_nxt = trig_addr_q;
    wrapped_nxt   = wrapped_q;
    wr_nxt        = 1'b0;
    if (cmd_start) begin
      state_nxt   = ICETAP_ST_PRE_TRIGGER;
      ptr_nxt     = '0;
      cnt_nxt     = '0;
      wrapped_nxt = 1'b0;
    end else if (cmd_stop && (state_q == ICETAP_ST_PRE_TRIGGER ||
                              state_q == ICETAP_ST_POST_TRIGGER)) begin
      state_nxt = ICETAP_ST_DONE;
    end else begin
      case (state_q)
        ICETAP_ST_PRE_TRIGGER: begin
          if (trig_cond) begin
            wr_nxt        = 1'b1;
            trig_addr_nxt = ptr_q;
            ptr_nxt       = ptr_inc;
            state_nxt     = (post_trig_len == '0) ? ICETAP_ST_DONE : ICETAP_ST_POST_TRIGGER;
          end
`ifdef ICETAP_PRETRIG_WRAP_EN
          else if (store_cond) begin
            wr_nxt  = 1'b1;
            ptr_nxt = ptr_inc;
            if (ptr_q == '1) wrapped_nxt = 1'b1;
          end
`endif
        end
        ICETAP_ST_POST_TRIGGER: begin
          if (store_cond) begin
            wr_nxt  = 1'b1;
            ptr_nxt = ptr_inc;
            cnt_nxt = cnt_inc[ADDR_BITS-1:0];
            // Stop before the window would overwrite the trigger sample
            if (cnt_inc == {1'b0, post_trig_len} || ptr_inc == trig_addr_q)
              state_nxt = ICETAP_ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      wrapped_q   <= 1'b0;
      wr_ena_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      ptr_q       <= ptr_nxt;
      cnt_q       <= cnt_nxt;
      trig_addr_q <= trig_addr_nxt;
      wrapped_q   <= wrapped_nxt;
      wr_ena_q    <= wr_nxt;
      if (wr_nxt) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= sig_d;
      end
    end
  end

  assign ram.ram_wr_ena  = wr_ena_q;
  assign ram.ram_wr_addr = wr_addr_q;
  assign ram.ram_wr_data = wr_data_q;
  assign state           = state_q;
  assign trigger_addr    = trig_addr_q;
  assign last_addr       = wr_addr_q;
  assign wrapped         = wrapped_q;

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Bench for icetap_capture_ctrl: directed scenarios plus random stimulus against a capture reference model.
module tb_icetap_capture_ctrl;
  import icetap_pkg::*;

  localparam int NS = 4;
  localparam int AB = 4;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          reset_;
  logic [NS-1:0] signals;
  logic          cmd_start, cmd_stop;
  logic [NS-1:0] store_mask, trigger_mask, trigger_value;
  logic [AB-1:0] post_trig_len;
  logic [ICETAP_STATE_W-1:0] state;
  logic [AB-1:0] trigger_addr, last_addr;
  logic          wrapped;

  icetap_capture_ctrl_if #(.NR_SIGNALS(NS), .ADDR_BITS(AB)) ram_if ();

  icetap_capture_ctrl #(.NR_SIGNALS(NS), .ADDR_BITS(AB)) dut (
    .clk           (clk),
    .reset_        (reset_),
    .signals       (signals),
    .cmd_start     (cmd_start),
    .cmd_stop      (cmd_stop),
    .store_mask    (store_mask),
    .trigger_mask  (trigger_mask),
    .trigger_value (trigger_value),
    .post_trig_len (post_trig_len),
    .ram           (ram_if.master),
    .state         (state),
    .trigger_addr  (trigger_addr),
    .last_addr     (last_addr),
    .wrapped       (wrapped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: capture described as a pointer into a DEPTH-word ring
  int m_sig_d, m_sig_prev;
  int m_state, m_ptr, m_cnt, m_trig, m_wrapped;
  int m_wr, m_waddr, m_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sig_d = 0; m_sig_prev = 0;
    m_state = 0; m_ptr = 0; m_cnt = 0; m_trig = 0; m_wrapped = 0;
    m_wr = 0; m_waddr = 0; m_wdata = 0;
  endtask

  task automatic model_step(input int s, input bit st, input bit sp);
    int  sm, tm, tv, post;
    bit  store, trig, wrap_en;
    sm = int'(store_mask); tm = int'(trigger_mask); tv = int'(trigger_value);
    post = int'(post_trig_len);
`ifdef ICETAP_PRETRIG_WRAP_EN
    wrap_en = 1'b1;
`else
    wrap_en = 1'b0;
`endif
    store = (sm == 0) || (((m_sig_d ^ m_sig_prev) & sm) != 0);
    trig  = ((m_sig_d & tm) == (tv & tm));
    m_wr = 0;
    if (st) begin
      m_state = 1; m_ptr = 0; m_cnt = 0; m_wrapped = 0;
    end else if (sp && (m_state == 1 || m_state == 2)) begin
      m_state = 3;
    end else if (m_state == 1) begin
      if (trig) begin
        m_wr = 1; m_waddr = m_ptr; m_trig = m_ptr;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_state = (post == 0) ? 3 : 2;
      end else if (wrap_en && store) begin
        m_wr = 1; m_waddr = m_ptr;
        if (m_ptr == DEPTH - 1) m_wrapped = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end else if (m_state == 2 && store) begin
      m_wr = 1; m_waddr = m_ptr;
      m_cnt = m_cnt + 1;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_cnt == post || m_ptr == m_trig) m_state = 3;
    end
    if (m_wr != 0) m_wdata = m_sig_d;
    m_sig_prev = m_sig_d;
    m_sig_d    = s;
  endtask

  task automatic compare_all();
    chk("wr_ena",       32'(ram_if.ram_wr_ena),  32'(m_wr));
    chk("wr_addr",      32'(ram_if.ram_wr_addr), 32'(m_waddr));
    chk("wr_data",      32'(ram_if.ram_wr_data), 32'(m_wdata));
    chk("state",        32'(state),              32'(m_state));
    chk("trigger_addr", 32'(trigger_addr),       32'(m_trig));
    chk("last_addr",    32'(last_addr),          32'(m_waddr));
    chk("wrapped",      32'(wrapped),            32'(m_wrapped));
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, compare 1 ns later
  task automatic cycle(input logic [NS-1:0] s, input bit st, input bit sp);
    signals = s; cmd_start = st; cmd_stop = sp;
    @(posedge clk);
    model_step(int'(s), st, sp);
    #1;
    compare_all();
    @(negedge clk);
    cmd_start = 1'b0; cmd_stop = 1'b0;
  endtask

  task automatic set_cfg(input int sm, input int tm, input int tv, input int post);
    store_mask = NS'(sm); trigger_mask = NS'(tm); trigger_value = NS'(tv);
    post_trig_len = AB'(post);
  endtask

  logic [NS-1:0] tog_seq [10];

  initial begin
    reset_ = 1'b0; signals = '0; cmd_start = 1'b0; cmd_stop = 1'b0;
    set_cfg(0, 0, 0, 0);
    model_reset();
    #2;
    compare_all();
    @(negedge clk); @(negedge clk);
    reset_ = 1'b1;

    // Zero trigger mask, post length 3: writes at 0,1,2,3 then DONE
    set_cfg(0, 0, 0, 3);
    cycle(4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(NS'(i + 5), 1'b0, 1'b0);
    chk("tp1_state", 32'(state), 32'(ICETAP_ST_DONE));
    chk("tp1_last", 32'(last_addr), 32'd3);
    chk("tp1_trig", 32'(trigger_addr), 32'd0);

    // Store mask on bit 0: bit 1 toggles store nothing, three bit-0 changes close the window
    set_cfg(1, 0, 0, 3);
    tog_seq = '{4'h2, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1};
    cycle(4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(tog_seq[i], 1'b0, 1'b0);
    chk("mask_state", 32'(state), 32'(ICETAP_ST_DONE));
    chk("mask_last", 32'(last_addr), 32'd3);

    // 20 samples then trigger, post length 0
    set_cfg(0, 8, 8, 0);
    cycle(4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) cycle(4'h0, 1'b0, 1'b0);
    cycle(4'h8, 1'b0, 1'b0);
    cycle(4'h0, 1'b0, 1'b0);
    cycle(4'h0, 1'b0, 1'b0);
`ifdef ICETAP_PRETRIG_WRAP_EN
    chk("wrap20_trig", 32'(trigger_addr), 32'd4);
    chk("wrap20_wrapped", 32'(wrapped), 32'd1);
`else
    chk("wrap20_trig", 32'(trigger_addr), 32'd0);
    chk("wrap20_wrapped", 32'(wrapped), 32'd0);
`endif
    chk("wrap20_state", 32'(state), 32'(ICETAP_ST_DONE));

    // 21 samples then trigger, longest window: the trigger word is never overwritten
    set_cfg(0, 8, 8, 15);
    cycle(4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(4'h0, 1'b0, 1'b0);
    cycle(4'h8, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(NS'(i), 1'b0, 1'b0);
    chk("win_state", 32'(state), 32'(ICETAP_ST_DONE));
`ifdef ICETAP_PRETRIG_WRAP_EN
    chk("win_trig", 32'(trigger_addr), 32'd5);
    chk("win_last", 32'(last_addr), 32'd4);
`else
    chk("win_trig", 32'(trigger_addr), 32'd0);
    chk("win_last", 32'(last_addr), 32'd15);
`endif

    // Stop during the post-trigger window
    set_cfg(0, 0, 0, 10);
    cycle(4'h0, 1'b1, 1'b0);
    cycle(4'h3, 1'b0, 1'b0);
    cycle(4'h5, 1'b0, 1'b0);
    cycle(4'h6, 1'b0, 1'b1);
    chk("stop_state", 32'(state), 32'(ICETAP_ST_DONE));
    for (int i = 0; i < 3; i++) cycle(4'h7, 1'b0, 1'b0);
    chk("stop_last", 32'(last_addr), 32'd1);

    // Start and stop together: start wins and the pointer restarts at 0
    cycle(4'h9, 1'b1, 1'b1);
    chk("startstop_state", 32'(state), 32'(ICETAP_ST_PRE_TRIGGER));
    cycle(4'h2, 1'b0, 1'b0);
    chk("startstop_addr", 32'(ram_if.ram_wr_addr), 32'd0);
    cycle(4'h1, 1'b0, 1'b0);
    cycle(4'h4, 1'b0, 1'b0);

    // Asynchronous reset mid post-trigger window
    chk("pre_rst_state", 32'(state), 32'(ICETAP_ST_POST_TRIGGER));
    #2 reset_ = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
    reset_ = 1'b1;

    // Random traffic with occasional reconfiguration and commands
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0)
        set_cfg($urandom_range(0, 15) & $urandom_range(0, 15),
                $urandom_range(0, 15) & $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15));
      cycle(NS'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
